// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: data width, default bit timing and transmitter FSM encoding.
package uart_tx_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLK_TX_FREQ  = 12_000_000;
  localparam int UART_BAUD         = 115_200;
  localparam int UART_CLKS_PER_BIT = UART_CLK_TX_FREQ / UART_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO; the extra pointer MSB separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Full is judged on the current pointers, so a full FIFO refuses a write even during a pop.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately unreset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter: FIFO-fed, LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [UART_DATA_W-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   tx_o,
  output logic                   busy_o
);

  localparam int               DIV_W     = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam int               BIT_W     = $clog2(UART_DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_rdata;
  logic                   bit_done, load;

  sync_fifo #(
    .WIDTH(UART_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push_i (valid_i),
    .wdata_i(data_i),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign bit_done = (div_q == DIV_LAST);

  // NOTE: every flop uses <= so all state advances together on the edge, independent of block order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: each always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (bit_done) state_d = ST_DATA;
      ST_DATA:   if (bit_done && bit_q == BIT_LAST)
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done && stop_q == LAST_STOP)
                   state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A pop happens whenever a new frame starts, from IDLE or straight out of the last stop cycle.
  assign load = (state_d == ST_START) && (state_q != ST_START);

  always_comb begin
    fifo_pop = 1'b0;
    div_d    = (state_q == ST_IDLE || bit_done) ? '0 : div_q + DIV_ONE;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    if (load) begin
      fifo_pop = 1'b1;
      div_d    = '0;
      stop_d   = 1'b0;
      shift_d  = fifo_rdata;
      par_d    = 1'b0;
      tx_d     = 1'b0;
    end else if (bit_done) begin
      unique case (state_q)
        ST_START: begin
          tx_d    = shift_q[0];
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
          bit_d   = '0;
        end
        ST_DATA: begin
          if (bit_q == BIT_LAST) begin
            tx_d   = (PARITY_EN != 0) ? (par_q ^ PAR_ODD) : 1'b1;
            stop_d = 1'b0;
          end else begin
            tx_d    = shift_q[0];
            par_d   = par_q ^ shift_q[0];
            shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
            bit_d   = bit_q + BIT_ONE;
          end
        end
        ST_PARITY: begin
          tx_d   = 1'b1;
          stop_d = 1'b0;
        end
        ST_STOP: begin
          tx_d = 1'b1;
          if (stop_q != LAST_STOP) stop_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = !fifo_full;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != ST_IDLE) || !fifo_empty;

endmodule
